// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: fetches FETCH_WIDTH words per cycle into a circular
// buffer and presents the oldest FETCH_WIDTH entries to the decoder.
module instruction_fetch_queue #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] START_PC    = 32'h0000_3000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic [31:0]                       imem_addr,
  input  logic [FETCH_WIDTH*32-1:0]         imem_data,
  input  logic                              redirect_valid,
  input  logic [31:0]                       redirect_pc,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]  deq_count,
  output logic [FETCH_WIDTH-1:0]            out_valid,
  output logic [FETCH_WIDTH*32-1:0]         out_instr,
  output logic [FETCH_WIDTH*32-1:0]         out_pc,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          fetch;
  logic [CW-1:0] deq_ext;
  logic [CW-1:0] eff_deq;
  logic [CW-1:0] count_nxt;
  logic          unused_pc_lsb;

  assign imem_addr     = fetch_pc;
  assign count         = count_q;
  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Free space is judged on the registered count only; a same-cycle dequeue
  // does not make room for this cycle's fetch.
  assign fetch     = !redirect_valid && ((CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH));
  assign deq_ext   = CW'(deq_count);
  assign eff_deq   = (deq_ext < count_q) ? deq_ext : count_q;
  assign count_nxt = count_q + (fetch ? CW'(FETCH_WIDTH) : '0) - eff_deq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= START_PC;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else begin
      head    <= head + PW'(eff_deq);
      count_q <= count_nxt;
      if (fetch) begin
        tail     <= tail + PW'(FETCH_WIDTH);
        fetch_pc <= fetch_pc + 32'(4*FETCH_WIDTH);
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && fetch) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        instr_mem[tail + PW'(k)] <= imem_data[32*k +: 32];
        pc_mem[tail + PW'(k)]    <= fetch_pc + 32'(4*k);
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (count_q > CW'(k)) begin
        out_valid[k]        = 1'b1;
        out_instr[32*k +: 32] = instr_mem[head + PW'(k)];
        out_pc[32*k +: 32]    = pc_mem[head + PW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with a {pc,instr} scoreboard
// queue modelling occupancy, fetch PC and head-entry contents.
module tb_instruction_fetch_queue;

  localparam int          FW       = 2;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] START_PC = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [63:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  deq_count;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic [63:0] out_pc;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb [$];
  logic [31:0] mfpc;

  instruction_fetch_queue #(
    .FETCH_WIDTH(FW), .DEPTH(DEPTH), .START_PC(START_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_count(deq_count), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: word at 0x3000 is 1, 0x3004 is 2, and so on.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) - 32'h0000_0BFF;
  endfunction

  always_comb begin
    imem_data = '0;
    for (int k = 0; k < FW; k++) imem_data[32*k +: 32] = mem_word(imem_addr + 32'(4*k));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [1:0] ev;
    ev = '0;
    chk("imem_addr", imem_addr, mfpc);
    chk("count", 32'(count), 32'(sb.size()));
    for (int k = 0; k < FW; k++) begin
      if (k < sb.size()) begin
        ev[k] = 1'b1;
        chk($sformatf("out_pc[%0d]", k), out_pc[32*k +: 32], sb[k][63:32]);
        chk($sformatf("out_instr[%0d]", k), out_instr[32*k +: 32], sb[k][31:0]);
      end else begin
        chk($sformatf("out_pc_zero[%0d]", k), out_pc[32*k +: 32], 32'h0);
        chk($sformatf("out_instr_zero[%0d]", k), out_instr[32*k +: 32], 32'h0);
      end
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
  endtask

  // Called at a falling edge: drive inputs, advance the model, clock, check.
  task automatic step(input int deq, input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
    int eff;
    bit mfetch;
    deq_count      = 2'(deq);
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    mfetch = !redir && ((DEPTH - sb.size()) >= FW);
    if (redir) begin
      sb.delete();
      mfpc = {rpc[31:2], 2'b00};
    end else begin
      eff = (deq < sb.size()) ? deq : sb.size();
      repeat (eff) void'(sb.pop_front());
      if (mfetch) begin
        for (int k = 0; k < FW; k++)
          sb.push_back({mfpc + 32'(4*k), mem_word(mfpc + 32'(4*k))});
        mfpc = mfpc + 32'(4*FW);
      end
    end
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    deq_count      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mfpc           = START_PC;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("rst_addr", imem_addr, 32'h3000);
    @(negedge clk);
    rst_n = 1'b1;

    step(0);
    chk("first_count", 32'(count), 32'd2);
    chk("first_pc1", out_pc[63:32], 32'h3004);
    chk("first_pc0", out_pc[31:0], 32'h3000);
    chk("first_instr1", out_instr[63:32], 32'h2);
    chk("first_instr0", out_instr[31:0], 32'h1);
    chk("first_addr", imem_addr, 32'h3008);

    repeat (3) step(0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_addr", imem_addr, 32'h3020);
    step(0);
    chk("stall_count", 32'(count), 32'd8);
    chk("stall_addr", imem_addr, 32'h3020);

    step(1);
    chk("deq1_count", 32'(count), 32'd7);
    step(1);
    chk("deq2_count", 32'(count), 32'd6);
    chk("deq2_addr", imem_addr, 32'h3020);
    step(0);
    chk("refill_count", 32'(count), 32'd8);
    chk("refill_addr", imem_addr, 32'h3028);

    step(1);
    step(2);
    chk("pre_redir_count", 32'(count), 32'd5);
    step(2, 1'b1, 32'h0000_3103);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h3100);

    // Dequeue request larger than occupancy is clamped to zero here.
    step(2);
    chk("clamp_count", 32'(count), 32'd2);
    chk("clamp_pc0", out_pc[31:0], 32'h3100);

    for (int i = 0; i < 12; i++) begin
      step(2);
      chk("steady_count", 32'(count), 32'd2);
      chk("steady_order", out_pc[63:32] - out_pc[31:0], 32'd4);
    end

    // Asynchronous reset in mid-cycle empties the queue at once.
    step(0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    mfpc = START_PC;
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    step(0);
    chk("post_rst_pc0", out_pc[31:0], 32'h3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
